// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared constants for the fetch redirect controller: vector address, FSM encoding,
// Cause register field layout and the interrupt exception code.
package fetch_redirect_ctrl_pkg;

    localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_4180;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam int CAUSE_CODE_LSB = 2;
    localparam int CAUSE_CODE_MSB = 6;
    localparam int CAUSE_IP_LSB   = 10;
    localparam int CAUSE_IP_MSB   = 15;
    localparam int CAUSE_BD_BIT   = 31;

    localparam logic [4:0] EXC_CODE_INT = 5'd0;

    function automatic logic [31:0] build_cause(input logic [4:0] code,
                                                input logic       bd,
                                                input logic [5:0] ip);
        logic [31:0] c;
        c = '0;
        c[CAUSE_CODE_MSB:CAUSE_CODE_LSB] = code;
        c[CAUSE_IP_MSB:CAUSE_IP_LSB]     = ip;
        c[CAUSE_BD_BIT]                  = bd;
        return c;
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_redirect_pending_buf.sv
// Single-entry buffer for a taken branch that arrived while fetch was stalled.
// A new load overwrites the held entry; clear drops it once issued or squashed.
module redirect_pending_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] loadTarget,
    input  logic        clear,
    output logic        pendValid,
    output logic [31:0] pendTarget
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pendValid  <= 1'b0;
            pendTarget <= '0;
        end else if (load) begin
            pendValid  <= 1'b1;
            pendTarget <= loadTarget;
        end else if (clear) begin
            pendValid  <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect arbiter: exceptions, eret, taken branches and deferred branches,
// plus EPC/Cause/EXL state. Optional interrupt entry is enabled by FETCH_IRQ_EN.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetchPC,
    input  logic        fetchException,
    input  logic        hazardStall,
    input  logic        brTaken,
    input  logic [31:0] brTarget,
    input  logic        exReq,
    input  logic [4:0]  exCode,
    input  logic [31:0] exPC,
    input  logic        exBD,
    input  logic        eret,
`ifdef FETCH_IRQ_EN
    input  logic [5:0]  irq,
    input  logic [5:0]  irqMask,
    input  logic        commitValid,
    input  logic [31:0] commitPC,
`endif
    output logic        absJump,
    output logic [31:0] absJumpAddress,
    output logic        pcStall,
    output logic        hang,
    output logic [31:0] epc,
    output logic [31:0] cause,
    output logic        exl
);

    state_t      state;
    state_t      state_next;
    logic        pend_load;
    logic        pend_clear;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        irq_take;
    logic [31:0] epc_q;
    logic [4:0]  code_q;
    logic        bd_q;
    logic [5:0]  ip_q;
    logic        exl_q;
    logic        jump;
    logic [31:0] jump_addr;
    logic        stall;
    logic        bubble;

    // The fetch PC is carried on the interface for debug visibility only.
    logic unused_fetch_pc;
    assign unused_fetch_pc = ^fetchPC;

`ifdef FETCH_IRQ_EN
    assign irq_take = (|(irq & irqMask)) & ~exl_q & commitValid & ~exReq;
`else
    assign irq_take = 1'b0;
`endif

    redirect_pending_buf u_pending (
        .clk        (clk),
        .reset      (reset),
        .load       (pend_load),
        .loadTarget (brTarget),
        .clear      (pend_clear),
        .pendValid  (pend_valid),
        .pendTarget (pend_target)
    );

    always_comb begin
        jump       = 1'b0;
        jump_addr  = '0;
        stall      = 1'b0;
        bubble     = 1'b0;
        pend_load  = 1'b0;
        pend_clear = 1'b0;
        state_next = state;
        if (reset) begin
            stall = hazardStall & ~(exReq | irq_take | eret);
            if (exReq || irq_take) begin
                jump       = 1'b1;
                jump_addr  = HANDLER_ADDR;
                pend_clear = 1'b1;
                state_next = ST_RUN;
            end else if (eret) begin
                jump       = 1'b1;
                jump_addr  = epc_q;
                pend_clear = 1'b1;
                state_next = ST_RUN;
            end else if (state == ST_HALT) begin
                bubble     = 1'b1;
                pend_clear = 1'b1;
            end else if (fetchException) begin
                // A faulting fetch squashes any branch arriving alongside it.
                bubble     = 1'b1;
                pend_clear = 1'b1;
                state_next = ST_HALT;
            end else if (brTaken) begin
                if (hazardStall) begin
                    pend_load = 1'b1;
                end else begin
                    jump       = 1'b1;
                    jump_addr  = brTarget;
                    pend_clear = 1'b1;
                end
            end else if (pend_valid && !hazardStall) begin
                jump       = 1'b1;
                jump_addr  = pend_target;
                pend_clear = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_RUN;
            epc_q  <= '0;
            code_q <= '0;
            bd_q   <= 1'b0;
            ip_q   <= '0;
            exl_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (exReq) begin
                // A nested exception redirects but must not overwrite the saved context.
                if (!exl_q) begin
                    epc_q  <= exBD ? (exPC - 32'd4) : exPC;
                    code_q <= exCode;
                    bd_q   <= exBD;
                    exl_q  <= 1'b1;
                end
            end else if (irq_take) begin
`ifdef FETCH_IRQ_EN
                epc_q  <= commitPC;
                code_q <= EXC_CODE_INT;
                bd_q   <= 1'b0;
                ip_q   <= irq;
                exl_q  <= 1'b1;
`endif
            end else if (eret) begin
                exl_q <= 1'b0;
            end
        end
    end

    assign absJump        = jump;
    assign absJumpAddress = jump_addr;
    assign pcStall        = stall;
    assign hang           = bubble;
    assign epc            = epc_q;
    assign cause          = build_cause(code_q, bd_q, ip_q);
    assign exl            = exl_q;

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Drives the redirect side of the instruction fetch unit: `absJump`, `absJumpAddress`, `pcStall` and `hang`. It arbitrates branch and jump targets from decode, exception requests from the commit stage, `eret` and hazard stalls. It holds redirects that arrive while fetch is stalled, and keeps the EPC, Cause and EXL state. It sits between decode/commit and fetch, and is the only block that moves the fetch PC off its sequential path.

## Interface
- `HANDLER_ADDR`, default 32'h0000_4180: exception vector in bytes.
- `clk`  in  1: clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-low; state clears on a posedge where `reset`==0.
- `fetchPC`  in  32: current fetch PC (fetch unit `outputPC`).
- `fetchException`  in  1: fetch address error (PC out of range or misaligned).
- `hazardStall`  in  1: hazard unit requests that fetch hold.
- `brTaken`  in  1, `brTarget`  in  32: resolved taken branch or jump from decode (one-cycle pulse).
- `exReq`  in  1, `exCode`  in  5, `exPC`  in  32, `exBD`  in  1: commit-stage exception request, code, faulting PC, and delay-slot flag.
- `eret`  in  1: exception return at commit.
- `absJump`  out  1, `absJumpAddress`  out  32: fetch redirect and its target.
- `pcStall`  out  1, `hang`  out  1: fetch hold and fetch bubble.
- `epc`  out  32, `cause`  out  32, `exl`  out  1: architectural exception state. `cause[6:2]` = code, `cause[31]` = BD.

## Operation
- FSM states: RUN and HALT. A separate pending-redirect register holds `pendValid` and `pendTarget`.
- Redirect priority, highest first: `exReq`, then `eret`, then `brTaken`, then `pendValid`.
- `exReq`:
  - Outputs `absJump`=1 and `absJumpAddress`=HANDLER_ADDR in the same cycle.
  - Forces `pcStall`=0.
  - Clears pending; next state is RUN.
  - If `exl`==0: EPC <= `exBD` ? `exPC`-4 : `exPC`; cause code <= `exCode`; BD <= `exBD`; `exl` <= 1.
  - If `exl`==1: EPC and Cause are left unchanged, but the redirect still happens.
- `eret`: `absJump`=1, target = EPC, `pcStall` forced to 0, `exl` <= 0, pending cleared, next state RUN.
- `brTaken` while `hazardStall`==0: immediate redirect to `brTarget`.
- `brTaken` while `hazardStall`==1: latched into pending. `absJump`=0 and `pcStall`=1 that cycle.
- Pending is issued on the first cycle with `hazardStall`==0, then cleared.
- A new `brTaken` overwrites an existing pending entry (latest wins).
- `pcStall` = `hazardStall` & ~(`exReq` | `eret`).
- RUN to HALT: `fetchException`=1 with no `exReq` or `eret` that cycle. `hang`=1 in that same cycle.
- HALT:
  - `hang`=1 continuously.
  - `brTaken` and pending entries are discarded.
  - Leaves only on `exReq` or `eret`.
- Arithmetic: EPC-4 is 32-bit modulo; no range check.

## Timing
- Immediate redirects are combinational (zero cycles), sampled by fetch on the same posedge.
- A deferred branch issues in the first cycle with `hazardStall` low, which can be the same cycle the stall drops.
- Reset values: state RUN, `pendValid`=0, `pendTarget`=0, `epc`=0, `cause`=0, `exl`=0.
- During reset the outputs are `absJump`=0, `absJumpAddress`=0, `pcStall`=0 and `hang`=0.
- Reset asserted with a branch pending: the pending entry is dropped.
- Reset asserted in HALT: returns to RUN.
- Simultaneous `exReq`+`brTaken`: the branch is dropped.
- Simultaneous `exReq`+`eret`: the exception wins and `exl` ends at 1.
- Simultaneous `fetchException`+`exReq`: the exception redirect is taken and HALT is not entered.

## Configuration
- `FETCH_IRQ_EN` defined adds:
  - Inputs `irq` [5:0], `irqMask` [5:0], `commitValid` and `commitPC` [32].
  - An interrupt is taken when `|(irq & irqMask)`, `exl`==0, `commitValid`==1 and `exReq`==0.
  - It is handled as an exception with code 0: EPC <= `commitPC`, `cause[15:10]` <= `irq`.
  - Priority sits between `exReq` and `eret`.
- `FETCH_IRQ_EN` undefined: these ports are absent and `cause[15:10]` reads 0.

## Structure
- Shared constants package holds:
  - Default HANDLER_ADDR.
  - FSM state encoding (RUN, HALT).
  - Cause field bit positions and the interrupt exception code.
- One natural sub-module: `redirect_pending_buf`, the pending register with overwrite/issue/clear logic.

## Test plan
- Reset low 2 cycles, then high → all outputs 0, `exl`=0, next cycle `absJump`=0.
- `brTaken`=1, `brTarget`=0x3040, `hazardStall`=0 → same-cycle `absJump`=1, `absJumpAddress`=0x3040.
- `brTaken` to 0x3080 with `hazardStall`=1 for 3 cycles → `pcStall`=1 and `absJump`=0 for those 3 cycles; in cycle 4 `absJump`=1 to 0x3080.
- `exReq`, code 4, `exPC`=0x3010, `exBD`=1 → redirect to 0x4180, `epc`=0x300C, `cause[6:2]`=4, `cause[31]`=1, `exl`=1. Then `eret` → redirect to 0x300C, `exl`=0.
- `fetchException`=1 → `hang`=1 from that cycle. `brTaken` to 0x3100 is ignored. `exReq` 5 cycles later → redirect to 0x4180, `hang`=0.
- `exReq` and `brTaken` in the same cycle with `hazardStall`=1 → `pcStall`=0, target 0x4180, pending empty afterwards.
